mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_arb_prio.sv | 59 +++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the instruction/data memory arbiter.
// The access-width codes match the ones the memory controller decodes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ST1  = 2'd2,
    ST_ST2  = 2'd3
  } arb_state_e;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Command captured from the winning requester at grant time
  typedef struct packed {
    logic        is_data;
    logic [1:0]  width;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  localparam mem_cmd_t CMD_NONE = '0;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// arb_prio: picks the winner between fetch and data in an arbitration cycle.
// With MEM_ARB_STARVE_GUARD_EN defined, a starvation counter lets fetch win
// after STARVE_LIMIT consecutive losses; otherwise data always has priority.
module arb_prio
  import mem_arbiter_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
  parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
`ifdef MEM_ARB_STARVE_GUARD_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic grant_if,
  output logic grant_d
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic       fetch_force;

  // Winner select; a starved fetch overrides data, and the loss count tracks it
  always_comb begin
    fetch_force  = (starve_cnt_q == LIMIT);
    grant_if     = (arb_en == ENABLE) & if_req & (~d_req | fetch_force);
    grant_d      = (arb_en == ENABLE) & d_req & ~grant_if;
    starve_cnt_d = starve_cnt_q;
    if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_d && if_req && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict data priority; fetch only wins when data is absent
  always_comb begin
    grant_d  = (arb_en == ENABLE) & d_req;
    grant_if = (arb_en == ENABLE) & if_req & ~d_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-controller port between instruction fetch
// and data accesses. Reads take 2 cycles (IDLE, RD), stores 3 (IDLE, ST1, ST2).
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (fetch starvation guard).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_is_store,
  output logic [31:0] m_addr,
  output logic [1:0]  m_width,
  output logic        m_unsigned,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  arb_state_e state_q, state_d;
  mem_cmd_t   cmd_q, cmd_d;
  logic       arb_en;
  logic       grant_if;
  logic       grant_d;

  // Limits outside 1..15 cannot be represented by the 4-bit loss counter
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
  end

  assign arb_en = ((state_q == ST_IDLE) && !rst) ? ENABLE : DISABLE;

  arb_prio
`ifdef MEM_ARB_STARVE_GUARD_EN
  #(
    .STARVE_LIMIT(STARVE_LIMIT)
  )
`endif
  u_arb_prio (
`ifdef MEM_ARB_STARVE_GUARD_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .arb_en   (arb_en),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Next state and command latch; a winner is only captured from IDLE
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          cmd_d.is_data     = 1'b0;
          cmd_d.width       = MEM_WORD;
          cmd_d.is_unsigned = 1'b0;
          cmd_d.addr        = if_addr;
          cmd_d.wdata       = 32'd0;
          state_d           = ST_RD;
        end else if (grant_d) begin
          cmd_d.is_data     = 1'b1;
          cmd_d.width       = d_width;
          cmd_d.is_unsigned = d_unsigned;
          cmd_d.addr        = d_addr;
          cmd_d.wdata       = d_we ? d_wdata : 32'd0;
          state_d           = d_we ? ST_ST1 : ST_RD;
        end
      end
      ST_RD:   state_d = ST_IDLE;
      ST_ST1:  state_d = ST_ST2;
      ST_ST2:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // Output decode from the registered state; everything is forced low in reset
  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = 32'd0;
    d_rvalid   = 1'b0;
    d_rdata    = 32'd0;
    m_is_store = 1'b0;
    m_addr     = 32'd0;
    m_width    = 2'd0;
    m_unsigned = 1'b0;
    m_wdata    = 32'd0;
    busy       = 1'b0;
    if (!rst) begin
      busy = (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if_gnt = grant_if;
          d_gnt  = grant_d;
        end
        ST_RD: begin
          m_addr     = cmd_q.addr;
          m_width    = cmd_q.width;
          m_unsigned = cmd_q.is_unsigned;
          m_wdata    = cmd_q.wdata;
          if (cmd_q.is_data) begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = m_rdata;
          end
        end
        ST_ST1: begin
          m_is_store = 1'b1;
          m_addr     = cmd_q.addr;
          m_width    = cmd_q.width;
          m_unsigned = cmd_q.is_unsigned;
          m_wdata    = cmd_q.wdata;
        end
        ST_ST2: begin
          m_addr     = cmd_q.addr;
          m_width    = cmd_q.width;
          m_unsigned = cmd_q.is_unsigned;
          m_wdata    = cmd_q.wdata;
          d_rvalid   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
